control_sequencer: RTL and testbench

Hardwired Moore control unit that sequences the 32-bit bus datapath through fetch, decode and execute.
- Drives every register enable (e_*), bus-source select (s_*), incPC, the ALU op code and the memory read/write handshake.
- Sits beside the datapath and takes the IR contents back as input.
- Supports reg-reg ALU ops (add/sub/and/or), mul/div into HI/LO, ld/st with base+offset, nop and halt.

---
 rtl/control_sequencer_if.sv | 36 +++
 rtl/control_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer (master) and the bus datapath/memory (slave).
// Outputs are decoded combinationally; memory requests stall until mem_done is returned.
interface control_sequencer_if #(
   parameter int ALU_OP_W = 4
);
   logic [31:0]         ir;
   logic                mem_done;
   logic                stop;

   logic [15:0]         r_en;
   logic [15:0]         r_out;
   logic                e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR;
   logic                s_PC, s_MDR, s_Zhigh, s_Zlow, s_HI, s_LO, s_C;
   logic                mdr_read;
   logic                incPC;
   logic [ALU_OP_W-1:0] alu_op;
   logic                mem_read, mem_write;
   logic                halted;
   logic                mem_err;

   modport master (
      input  ir, mem_done, stop,
      output r_en, r_out,
      output e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR,
      output s_PC, s_MDR, s_Zhigh, s_Zlow, s_HI, s_LO, s_C,
      output mdr_read, incPC, alu_op, mem_read, mem_write, halted, mem_err
   );

   modport slave (
      output ir, mem_done, stop,
      input  r_en, r_out,
      input  e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR,
      input  s_PC, s_MDR, s_Zhigh, s_Zlow, s_HI, s_LO, s_C,
      input  mdr_read, incPC, alu_op, mem_read, mem_write, halted, mem_err
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore control unit stepping the bus datapath through fetch/decode/execute (T0..T7, HALT).
// Memory states stall until mem_done; a stall of WAIT_LIMIT cycles raises mem_err and halts.
module control_sequencer #(
   parameter int WAIT_LIMIT = 15,
   parameter int ALU_OP_W   = 4
) (
   input  logic                clock,
   input  logic                clear,
   control_sequencer_if.master bus
);
   typedef enum logic [3:0] {
      T0, T1, T2, T3, T4, T5, T6, T7, HALT
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] ALU_MUL = ALU_OP_W'(4);
   localparam logic [ALU_OP_W-1:0] ALU_DIV = ALU_OP_W'(5);

   localparam int               CNT_W    = $clog2(WAIT_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;

   logic [4:0]          opcode;
   logic [3:0]          ra, rb, rc;
   logic                is_alu, is_muldiv, is_ld, is_st, is_halt;
   logic [ALU_OP_W-1:0] alu_code;
   logic                in_wait, wait_tmo;

   function automatic logic [15:0] onehot(input logic [3:0] idx);
      logic [15:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Instruction decode; nop and every undefined opcode fall through with no class set.
   always_comb begin
      opcode    = bus.ir[31:27];
      ra        = bus.ir[26:23];
      rb        = bus.ir[22:19];
      rc        = bus.ir[18:15];
      is_alu    = 1'b0;
      is_muldiv = 1'b0;
      is_ld     = 1'b0;
      is_st     = 1'b0;
      is_halt   = 1'b0;
      alu_code  = ALU_ADD;
      case (opcode)
         OP_ADD:  begin is_alu    = 1'b1; alu_code = ALU_ADD; end
         OP_SUB:  begin is_alu    = 1'b1; alu_code = ALU_SUB; end
         OP_AND:  begin is_alu    = 1'b1; alu_code = ALU_AND; end
         OP_OR:   begin is_alu    = 1'b1; alu_code = ALU_OR;  end
         OP_MUL:  begin is_muldiv = 1'b1; alu_code = ALU_MUL; end
         OP_DIV:  begin is_muldiv = 1'b1; alu_code = ALU_DIV; end
         OP_LD:   is_ld   = 1'b1;
         OP_ST:   is_st   = 1'b1;
         OP_HALT: is_halt = 1'b1;
         default: ;
      endcase
   end

   // mem_done on the last permitted wait cycle still counts as completion.
   always_comb begin
      in_wait  = (state_q == T1) || (state_q == T6 && is_ld) || (state_q == T7 && is_st);
      wait_tmo = in_wait && !bus.mem_done && (wait_cnt_q == CNT_LAST);
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      mem_err_d  = mem_err_q | wait_tmo;
      if (in_wait && !bus.mem_done && !wait_tmo) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (wait_tmo) begin
         state_d = HALT;
      end else begin
         case (state_q)
            T0:      state_d = bus.stop ? HALT : T1;
            T1:      if (bus.mem_done) state_d = T2;
            T2:      state_d = T3;
            T3: begin
               if (is_alu || is_muldiv || is_ld || is_st) state_d = T4;
               else if (is_halt)                          state_d = HALT;
               else                                       state_d = T0;
            end
            T4:      state_d = T5;
            T5:      state_d = (is_muldiv || is_ld || is_st) ? T6 : T0;
            T6: begin
               if (is_ld)      state_d = bus.mem_done ? T7 : T6;
               else if (is_st) state_d = T7;
               else            state_d = T0;
            end
            T7: begin
               if (is_st) state_d = bus.mem_done ? T0 : T7;
               else       state_d = T0;
            end
            HALT:    state_d = HALT;
            default: state_d = T0;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q    <= T0;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_err_q  <= mem_err_d;
      end
   end

   // Datapath controls; clear silences everything in the same cycle it is held.
   always_comb begin
      bus.r_en      = '0;
      bus.r_out     = '0;
      bus.e_PC      = 1'b0;
      bus.e_IR      = 1'b0;
      bus.e_Y       = 1'b0;
      bus.e_Z       = 1'b0;
      bus.e_HI      = 1'b0;
      bus.e_LO      = 1'b0;
      bus.e_MAR     = 1'b0;
      bus.e_MDR     = 1'b0;
      bus.s_PC      = 1'b0;
      bus.s_MDR     = 1'b0;
      bus.s_Zhigh   = 1'b0;
      bus.s_Zlow    = 1'b0;
      bus.s_HI      = 1'b0;
      bus.s_LO      = 1'b0;
      bus.s_C       = 1'b0;
      bus.mdr_read  = 1'b0;
      bus.incPC     = 1'b0;
      bus.alu_op    = '0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.halted    = 1'b0;
      bus.mem_err   = 1'b0;
      if (!clear) begin
         bus.mem_err = mem_err_q;
         case (state_q)
            T0: begin
               if (!bus.stop) begin
                  bus.s_PC  = 1'b1;
                  bus.e_MAR = 1'b1;
                  bus.incPC = 1'b1;
               end
            end
            T1: begin
               bus.mem_read = 1'b1;
               bus.mdr_read = 1'b1;
               bus.e_MDR    = 1'b1;
            end
            T2: begin
               bus.s_MDR = 1'b1;
               bus.e_IR  = 1'b1;
            end
            T3: begin
               if (is_alu || is_ld || is_st) begin
                  bus.r_out = onehot(rb);
                  bus.e_Y   = 1'b1;
               end else if (is_muldiv) begin
                  bus.r_out = onehot(ra);
                  bus.e_Y   = 1'b1;
               end
            end
            T4: begin
               if (is_alu) begin
                  bus.r_out  = onehot(rc);
                  bus.alu_op = alu_code;
                  bus.e_Z    = 1'b1;
               end else if (is_muldiv) begin
                  bus.r_out  = onehot(rb);
                  bus.alu_op = alu_code;
                  bus.e_Z    = 1'b1;
               end else if (is_ld || is_st) begin
                  bus.s_C    = 1'b1;
                  bus.alu_op = ALU_ADD;
                  bus.e_Z    = 1'b1;
               end
            end
            T5: begin
               if (is_alu) begin
                  bus.s_Zlow = 1'b1;
                  bus.r_en   = onehot(ra);
               end else if (is_muldiv) begin
                  bus.s_Zlow = 1'b1;
                  bus.e_LO   = 1'b1;
               end else if (is_ld || is_st) begin
                  bus.s_Zlow = 1'b1;
                  bus.e_MAR  = 1'b1;
               end
            end
            T6: begin
               if (is_muldiv) begin
                  bus.s_Zhigh = 1'b1;
                  bus.e_HI    = 1'b1;
               end else if (is_ld) begin
                  bus.mem_read = 1'b1;
                  bus.mdr_read = 1'b1;
                  bus.e_MDR    = 1'b1;
               end else if (is_st) begin
                  bus.r_out = onehot(ra);
                  bus.e_MDR = 1'b1;
               end
            end
            T7: begin
               if (is_ld) begin
                  bus.s_MDR = 1'b1;
                  bus.r_en  = onehot(ra);
               end else if (is_st) begin
                  bus.mem_write = 1'b1;
               end
            end
            HALT:    bus.halted = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench: a per-instruction cycle script of expected controls is built from the
// instruction semantics and compared cycle by cycle against the sequencer.
module tb_control_sequencer;
   localparam int WAIT_LIMIT = 15;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef struct packed {
      logic [15:0] r_en;
      logic [15:0] r_out;
      logic e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR;
      logic s_PC, s_MDR, s_Zhigh, s_Zlow, s_HI, s_LO, s_C;
      logic mdr_read, incPC;
      logic [3:0] alu_op;
      logic mem_read, mem_write, halted, mem_err;
   } out_t;

   typedef struct {
      out_t        o;
      logic [31:0] ir;
      bit          md;
      bit          st;
      bit          clr;
   } cyc_t;

   logic clock = 1'b0;
   logic clear = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   cyc_t cq[$];
   logic [31:0] m_ir;

   control_sequencer_if #(.ALU_OP_W(4)) bus ();

   control_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .ALU_OP_W(4)) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [15:0] oh(input int i);
      logic [15:0] v;
      v = 16'h0001;
      return v << i;
   endfunction

   function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb,
                                      input logic [18:0] c);
      return {op, 4'(ra), 4'(rb), c};
   endfunction

   function automatic logic [3:0] alu_of(input logic [4:0] op);
      case (op)
         OP_SUB:  return 4'd1;
         OP_AND:  return 4'd2;
         OP_OR:   return 4'd3;
         OP_MUL:  return 4'd4;
         OP_DIV:  return 4'd5;
         default: return 4'd0;
      endcase
   endfunction

   function automatic bit is_def(input logic [4:0] op);
      return op inside {OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NOP, OP_HALT};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] op;
      case ($urandom_range(0, 8))
         0: op = OP_ADD;
         1: op = OP_SUB;
         2: op = OP_AND;
         3: op = OP_OR;
         4: op = OP_MUL;
         5: op = OP_DIV;
         6: op = OP_LD;
         7: op = OP_ST;
         default: op = OP_NOP;
      endcase
      return mk(op, $urandom_range(0, 15), $urandom_range(0, 15), 19'($urandom));
   endfunction

   function automatic out_t sample();
      out_t a;
      a.r_en = bus.r_en;       a.r_out = bus.r_out;
      a.e_PC = bus.e_PC;       a.e_IR = bus.e_IR;       a.e_Y = bus.e_Y;
      a.e_Z = bus.e_Z;         a.e_HI = bus.e_HI;       a.e_LO = bus.e_LO;
      a.e_MAR = bus.e_MAR;     a.e_MDR = bus.e_MDR;
      a.s_PC = bus.s_PC;       a.s_MDR = bus.s_MDR;     a.s_Zhigh = bus.s_Zhigh;
      a.s_Zlow = bus.s_Zlow;   a.s_HI = bus.s_HI;       a.s_LO = bus.s_LO;
      a.s_C = bus.s_C;         a.mdr_read = bus.mdr_read;
      a.incPC = bus.incPC;     a.alu_op = bus.alu_op;
      a.mem_read = bus.mem_read; a.mem_write = bus.mem_write;
      a.halted = bus.halted;   a.mem_err = bus.mem_err;
      return a;
   endfunction

   function automatic int nsel(input out_t a);
      return $countones(a.r_out) + int'(a.s_PC) + int'(a.s_MDR) + int'(a.s_Zhigh)
           + int'(a.s_Zlow) + int'(a.s_HI) + int'(a.s_LO) + int'(a.s_C);
   endfunction

   // ---- reference model: expected per-cycle controls for one instruction ----
   task automatic push(input out_t o, input bit md, input bit st);
      cyc_t c;
      c.o = o; c.ir = m_ir; c.md = md; c.st = st; c.clr = 1'b0;
      cq.push_back(c);
   endtask

   task automatic push_clear(input int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c.o = '0; c.ir = $urandom; c.md = rnd(); c.st = rnd(); c.clr = 1'b1;
         cq.push_back(c);
      end
   endtask

   task automatic halt_tail(input bit err);
      out_t o;
      o = '0; o.halted = 1'b1; o.mem_err = err;
      for (int i = 0; i < 3; i++) push(o, rnd(), rnd());
   endtask

   // Memory request held each cycle; done arrives after d idle cycles (d >= WAIT_LIMIT: never).
   task automatic mem_wait(input out_t o, input int d, output bit tmo);
      tmo = 1'b1;
      for (int k = 0; k < WAIT_LIMIT; k++) begin
         push(o, k == d, rnd());
         if (k == d) begin
            tmo = 1'b0;
            break;
         end
      end
   endtask

   task automatic add_instr(input logic [31:0] iv, input int d1, input int d2, input bit stp);
      logic [4:0] op;
      int ra, rb, rc;
      out_t o;
      bit tmo;
      op = iv[31:27]; ra = int'(iv[26:23]); rb = int'(iv[22:19]); rc = int'(iv[18:15]);
      m_ir = iv;
      o = '0;
      if (stp) begin
         push(o, rnd(), 1'b1);
         halt_tail(1'b0);
         return;
      end
      o.s_PC = 1'b1; o.e_MAR = 1'b1; o.incPC = 1'b1;
      push(o, rnd(), 1'b0);
      o = '0; o.mem_read = 1'b1; o.mdr_read = 1'b1; o.e_MDR = 1'b1;
      mem_wait(o, d1, tmo);
      if (tmo) begin
         halt_tail(1'b1);
         return;
      end
      o = '0; o.s_MDR = 1'b1; o.e_IR = 1'b1;
      push(o, rnd(), rnd());
      o = '0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            o.r_out = oh(rb); o.e_Y = 1'b1; push(o, rnd(), rnd());
            o = '0; o.r_out = oh(rc); o.alu_op = alu_of(op); o.e_Z = 1'b1; push(o, rnd(), rnd());
            o = '0; o.s_Zlow = 1'b1; o.r_en = oh(ra); push(o, rnd(), rnd());
         end
         OP_MUL, OP_DIV: begin
            o.r_out = oh(ra); o.e_Y = 1'b1; push(o, rnd(), rnd());
            o = '0; o.r_out = oh(rb); o.alu_op = alu_of(op); o.e_Z = 1'b1; push(o, rnd(), rnd());
            o = '0; o.s_Zlow = 1'b1; o.e_LO = 1'b1; push(o, rnd(), rnd());
            o = '0; o.s_Zhigh = 1'b1; o.e_HI = 1'b1; push(o, rnd(), rnd());
         end
         OP_LD, OP_ST: begin
            o.r_out = oh(rb); o.e_Y = 1'b1; push(o, rnd(), rnd());
            o = '0; o.s_C = 1'b1; o.e_Z = 1'b1; push(o, rnd(), rnd());
            o = '0; o.s_Zlow = 1'b1; o.e_MAR = 1'b1; push(o, rnd(), rnd());
            if (op == OP_LD) begin
               o = '0; o.mem_read = 1'b1; o.mdr_read = 1'b1; o.e_MDR = 1'b1;
               mem_wait(o, d2, tmo);
               if (tmo) begin
                  halt_tail(1'b1);
                  return;
               end
               o = '0; o.s_MDR = 1'b1; o.r_en = oh(ra); push(o, rnd(), rnd());
            end else begin
               o = '0; o.r_out = oh(ra); o.e_MDR = 1'b1; push(o, rnd(), rnd());
               o = '0; o.mem_write = 1'b1;
               mem_wait(o, d2, tmo);
               if (tmo) halt_tail(1'b1);
            end
         end
         OP_HALT: begin
            push(o, rnd(), rnd());
            halt_tail(1'b0);
         end
         default: push(o, rnd(), rnd());
      endcase
   endtask

   task automatic step(input cyc_t c, output out_t a);
      @(posedge clock);
      #1;
      clear = c.clr; bus.ir = c.ir; bus.mem_done = c.md; bus.stop = c.st;
      @(negedge clock);
      a = sample();
   endtask

   // ---- tests ----
   task automatic test_reset();
      cyc_t c; out_t a; int k;
      cq.delete();
      push_clear(2);
      add_instr(mk(OP_NOP, 0, 0, 19'h0), 0, 0, 1'b0);
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL reset cycle %0d: got %h, expected %h", k, a, c.o);
         end
         k++;
      end
   endtask

   task automatic test_alu();
      cyc_t c; out_t a; int k;
      logic [4:0] op;
      cq.delete();
      add_instr(mk(OP_ADD, 3, 1, {4'd2, 15'h0}), 0, 0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         case (i % 4)
            0: op = OP_ADD;
            1: op = OP_SUB;
            2: op = OP_AND;
            default: op = OP_OR;
         endcase
         add_instr(mk(op, $urandom_range(0, 15), $urandom_range(0, 15), 19'($urandom)),
                   $urandom_range(0, 3), 0, 1'b0);
      end
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL alu cycle %0d: got %h, expected %h", k, a, c.o);
         end
         n_tests++;
         if (nsel(a) > 1) begin
            n_fail++;
            $display("FAIL alu_bus_sel cycle %0d: got %0d selects, expected at most 1", k, nsel(a));
         end
         k++;
      end
   endtask

   task automatic test_muldiv();
      cyc_t c; out_t a; int k;
      cq.delete();
      add_instr(mk(OP_MUL, 6, 7, 19'h0), 0, 0, 1'b0);
      for (int i = 0; i < 4; i++)
         add_instr(mk(rnd() ? OP_MUL : OP_DIV, $urandom_range(0, 15), $urandom_range(0, 15),
                      19'($urandom)), $urandom_range(0, 2), 0, 1'b0);
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL muldiv cycle %0d: got %h, expected %h", k, a, c.o);
         end
         n_tests++;
         if (nsel(a) > 1) begin
            n_fail++;
            $display("FAIL muldiv_bus_sel cycle %0d: got %0d selects, expected at most 1", k, nsel(a));
         end
         k++;
      end
   endtask

   task automatic test_ld_st();
      cyc_t c; out_t a; int k;
      cq.delete();
      add_instr(mk(OP_LD, 2, 4, 19'h10), 0, 3, 1'b0);
      for (int i = 0; i < 6; i++)
         add_instr(mk(rnd() ? OP_LD : OP_ST, $urandom_range(0, 15), $urandom_range(0, 15),
                      19'($urandom)), $urandom_range(0, 2), $urandom_range(0, 5), 1'b0);
      add_instr(mk(OP_LD, 9, 3, 19'h7), 0, WAIT_LIMIT - 1, 1'b0);
      add_instr(mk(OP_ST, 4, 8, 19'h3), WAIT_LIMIT - 1, WAIT_LIMIT - 1, 1'b0);
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL ld_st cycle %0d: got %h, expected %h", k, a, c.o);
         end
         n_tests++;
         if (nsel(a) > 1) begin
            n_fail++;
            $display("FAIL ld_st_bus_sel cycle %0d: got %0d selects, expected at most 1", k, nsel(a));
         end
         k++;
      end
   endtask

   task automatic test_mem_timeout();
      cyc_t c; out_t a; int k;
      cq.delete();
      add_instr(mk(OP_ST, 5, 1, 19'h7FFFC), 0, WAIT_LIMIT, 1'b0);
      push_clear(1);
      add_instr(mk(OP_NOP, 0, 0, 19'h0), 0, 0, 1'b0);
      add_instr(mk(OP_NOP, 1, 1, 19'h1), WAIT_LIMIT, 0, 1'b0);
      push_clear(2);
      add_instr(mk(OP_LD, 1, 2, 19'h4), 1, WAIT_LIMIT, 1'b0);
      push_clear(1);
      add_instr(rand_instr(), 0, 1, 1'b0);
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL mem_timeout cycle %0d: got %h, expected %h", k, a, c.o);
         end
         k++;
      end
   endtask

   task automatic test_halt_stop();
      cyc_t c; out_t a; int k;
      logic [4:0] op;
      cq.delete();
      add_instr(32'hD800_0000, 0, 0, 1'b0);
      push_clear(1);
      add_instr(rand_instr(), 0, 0, 1'b1);
      push_clear(1);
      add_instr(mk(OP_NOP, 2, 3, 19'h5), 1, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         do op = 5'($urandom); while (is_def(op));
         add_instr(mk(op, $urandom_range(0, 15), $urandom_range(0, 15), 19'($urandom)), 0, 0, 1'b0);
      end
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL halt_stop cycle %0d: got %h, expected %h", k, a, c.o);
         end
         k++;
      end
   endtask

   task automatic test_clear_mid();
      cyc_t c; out_t a; int k;
      cq.delete();
      add_instr(mk(OP_LD, 2, 4, 19'h10), 0, WAIT_LIMIT, 1'b0);
      cq = cq[0:7];
      push_clear(1);
      add_instr(mk(OP_ADD, 7, 8, {4'd9, 15'h0}), 0, 0, 1'b0);
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL clear_mid cycle %0d: got %h, expected %h", k, a, c.o);
         end
         k++;
      end
   endtask

   task automatic test_back_to_back();
      cyc_t c; out_t a; int k;
      cq.delete();
      for (int i = 0; i < 20; i++)
         add_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 4), 1'b0);
      k = 0;
      while (cq.size() > 0) begin
         c = cq.pop_front();
         step(c, a);
         n_tests++;
         if (a !== c.o) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got %h, expected %h", k, a, c.o);
         end
         n_tests++;
         if (nsel(a) > 1) begin
            n_fail++;
            $display("FAIL b2b_bus_sel cycle %0d: got %0d selects, expected at most 1", k, nsel(a));
         end
         k++;
      end
   endtask

   initial begin
      bus.ir = '0;
      bus.mem_done = 1'b0;
      bus.stop = 1'b0;
      test_reset();
      test_alu();
      test_muldiv();
      test_ld_st();
      test_mem_timeout();
      test_halt_stop();
      test_clear_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no summary by time limit, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
